// File: rtl/line_render_sched.sv
// ============================================================================
// Module   : line_render_sched
// Purpose  : Per-line render scheduler. On each next_line pulse it flips the
//            line-buffer bank, latches the field and the stage enables, and
//            sequences the enabled stages L0 -> L1 -> SPR. Each stage gets a
//            one-cycle start pulse. The scheduler advances on that stage's
//            done pulse. A new line arriving while a stage is still running
//            aborts the renderer and raises an overrun pulse.
// Ports    : clk, rst (sync, active-high)
//            next_line, next_frame, current_field  - video timing inputs
//            layer0_en, layer1_en, sprites_en      - per-line stage enables
//            start_l0/_l1/_spr, done_l0/_l1/_spr   - stage handshake
//            abort, overrun                        - overrun reporting pulses
//            lb_sel, line_idx, render_field, busy  - line status
//            overrun_cnt                           - saturating overrun count
// Macro    : LINE_SCHED_OVERRUN_CNT_EN - enables the overrun counter.
//            When it is undefined, overrun_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_render_sched #(
  parameter int LINE_W = 9,
  parameter int OVR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_line,
  input  logic              next_frame,
  input  logic              current_field,
  input  logic              layer0_en,
  input  logic              layer1_en,
  input  logic              sprites_en,
  output logic              start_l0,
  output logic              start_l1,
  output logic              start_spr,
  input  logic              done_l0,
  input  logic              done_l1,
  input  logic              done_spr,
  output logic              abort,
  output logic              lb_sel,
  output logic [LINE_W-1:0] line_idx,
  output logic              render_field,
  output logic              busy,
  output logic              overrun,
  output logic [OVR_W-1:0]  overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L0   = 3'd1,
    S_L1   = 3'd2,
    S_SPR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d, after_q, first_d;
  logic [2:0]        en_q, en_d;          // {spr, l1, l0}, frozen for the line
  logic              start_l0_q, start_l1_q, start_spr_q;
  logic              abort_q, overrun_q, lb_sel_q, field_q, busy_q;
  logic [LINE_W-1:0] line_idx_q;
  logic              stage_act, done_acc, ovr_d, enter_d;

  // Next-state decode. A done pulse counts only in its own stage and only
  // after that stage's start cycle.
  always_comb begin
    stage_act = (state_q == S_L0) || (state_q == S_L1) || (state_q == S_SPR);
    done_acc  = (done_l0  && (state_q == S_L0)  && !start_l0_q) ||
                (done_l1  && (state_q == S_L1)  && !start_l1_q) ||
                (done_spr && (state_q == S_SPR) && !start_spr_q);

    // Stage that follows the current one under the latched enables.
    case (state_q)
      S_L0:    after_q = en_q[1] ? S_L1 : (en_q[2] ? S_SPR : S_DONE);
      S_L1:    after_q = en_q[2] ? S_SPR : S_DONE;
      S_SPR:   after_q = S_DONE;
      default: after_q = state_q;
    endcase

    en_d    = {sprites_en, layer1_en, layer0_en};
    first_d = en_d[0] ? S_L0 : (en_d[1] ? S_L1 : (en_d[2] ? S_SPR : S_DONE));

    // Completing the last enabled stage in the same cycle as next_line
    // counts as a finished line, not an overrun.
    ovr_d   = next_line && stage_act && !(done_acc && (after_q == S_DONE));
    enter_d = next_line || done_acc;

    if (next_line) begin
      state_d = first_d;
    end else if (done_acc) begin
      state_d = after_q;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_q        <= 3'b000;
      start_l0_q  <= 1'b0;
      start_l1_q  <= 1'b0;
      start_spr_q <= 1'b0;
      abort_q     <= 1'b0;
      overrun_q   <= 1'b0;
      lb_sel_q    <= 1'b0;
      field_q     <= 1'b0;
      busy_q      <= 1'b0;
      line_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_l0_q  <= enter_d && (state_d == S_L0);
      start_l1_q  <= enter_d && (state_d == S_L1);
      start_spr_q <= enter_d && (state_d == S_SPR);
      abort_q     <= ovr_d;
      overrun_q   <= ovr_d;
      busy_q      <= (state_d == S_L0) || (state_d == S_L1) || (state_d == S_SPR);
      if (next_line) begin
        en_q       <= en_d;
        lb_sel_q   <= ~lb_sel_q;
        field_q    <= current_field;
        line_idx_q <= next_frame ? '0 : line_idx_q + 1'b1;
      end
    end
  end

`ifdef LINE_SCHED_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_cnt_q;

  // The counter updates on the same edge that raises the overrun pulse. The
  // frame clear takes priority, so an overrun on the frame's first line
  // leaves the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else if (next_line && next_frame) begin
      ovr_cnt_q <= ovr_d ? {{(OVR_W-1){1'b0}}, 1'b1} : '0;
    end else if (ovr_d && (ovr_cnt_q != {OVR_W{1'b1}})) begin
      ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = '0;
`endif

  assign start_l0     = start_l0_q;
  assign start_l1     = start_l1_q;
  assign start_spr    = start_spr_q;
  assign abort        = abort_q;
  assign overrun      = overrun_q;
  assign lb_sel       = lb_sel_q;
  assign line_idx     = line_idx_q;
  assign render_field = field_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_line_render_sched.sv
// ============================================================================
// Module   : tb_line_render_sched
// Purpose  : Self-checking bench for line_render_sched. Every pulse the DUT
//            emits is matched against a scoreboard entry. The entry is pushed
//            when the stimulus that causes the pulse is driven. Level outputs
//            are checked directly at chosen points.
// Macro    : LINE_SCHED_OVERRUN_CNT_EN selects the expected counter behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_render_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       next_line = 1'b0, next_frame = 1'b0, current_field = 1'b0;
  logic       layer0_en = 1'b0, layer1_en = 1'b0, sprites_en = 1'b0;
  logic       done_l0 = 1'b0, done_l1 = 1'b0, done_spr = 1'b0;
  logic       start_l0, start_l1, start_spr, abort, lb_sel, render_field;
  logic       busy, overrun;
  logic [8:0] line_idx;
  logic [7:0] overrun_cnt;

  line_render_sched #(.LINE_W(9), .OVR_W(8)) u_dut (
    .clk(clk), .rst(rst), .next_line(next_line), .next_frame(next_frame),
    .current_field(current_field), .layer0_en(layer0_en),
    .layer1_en(layer1_en), .sprites_en(sprites_en), .start_l0(start_l0),
    .start_l1(start_l1), .start_spr(start_spr), .done_l0(done_l0),
    .done_l1(done_l1), .done_spr(done_spr), .abort(abort), .lb_sel(lb_sel),
    .line_idx(line_idx), .render_field(render_field), .busy(busy),
    .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: pulse vector {start_l0,start_l1,start_spr,abort,overrun}
  typedef struct {
    int         cyc;
    logic [4:0] p;
    logic       lb;
    logic [8:0] idx;
    logic       fld;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];

  // Reference line state maintained by the bench.
  logic       lb_m  = 1'b0;
  logic [8:0] idx_m = '0;
  logic       fld_m = 1'b0;
  logic [7:0] cnt_m = '0;

  task automatic push(input logic [4:0] p);
    exp_t e;
    e.cyc = cyc + 1;
    e.p   = p;
    e.lb  = lb_m;
    e.idx = idx_m;
    e.fld = fld_m;
    e.cnt = cnt_m;
    if (p != 5'b0) sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive one next_line pulse. en = {spr,l1,l0}. ovr = expected overrun.
  // dn = done pulses driven in the same cycle.
  task automatic line(input logic frame, input logic field, input logic [2:0] en,
                      input logic ovr, input logic [2:0] dn);
    logic [2:0] st;
    lb_m  = ~lb_m;
    idx_m = frame ? 9'd0 : idx_m + 9'd1;
    fld_m = field;
`ifdef LINE_SCHED_OVERRUN_CNT_EN
    if (frame) cnt_m = ovr ? 8'd1 : 8'd0;
    else if (ovr && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
`endif
    st = en[0] ? 3'b100 : (en[1] ? 3'b010 : (en[2] ? 3'b001 : 3'b000));
    push({st, ovr, ovr});
    next_line = 1'b1; next_frame = frame; current_field = field;
    layer0_en = en[0]; layer1_en = en[1]; sprites_en = en[2];
    {done_spr, done_l1, done_l0} = dn;
    step();
    next_line = 1'b0; next_frame = 1'b0;
    {done_spr, done_l1, done_l0} = 3'b000;
    // Enables change after the line has started; the latched copy must rule.
    layer0_en = ~en[0]; layer1_en = ~en[1]; sprites_en = ~en[2];
  endtask

  // dn = {spr,l1,l0} done pulses. exp_st = expected start {l0,l1,spr}.
  task automatic done_pulse(input logic [2:0] dn, input logic [2:0] exp_st);
    push({exp_st, 2'b00});
    {done_spr, done_l1, done_l0} = dn;
    step();
    {done_spr, done_l1, done_l0} = 3'b000;
  endtask

  // Pulse monitor: every pulse seen must match the scoreboard head.
  always @(negedge clk) begin
    logic [4:0] pa;
    exp_t e;
    pa = {start_l0, start_l1, start_spr, abort, overrun};
    if (pa != 5'b0) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_pulse", {27'b0, pa}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_cycle",  e.cyc == cyc, 1);
        check_eq("sb_pulses", {27'b0, pa}, {27'b0, e.p});
        check_eq("sb_lb_sel", {31'b0, lb_sel}, {31'b0, e.lb});
        check_eq("sb_line_idx", {23'b0, line_idx}, {23'b0, e.idx});
        check_eq("sb_field", {31'b0, render_field}, {31'b0, e.fld});
        check_eq("sb_ovr_cnt", {24'b0, overrun_cnt}, {24'b0, e.cnt});
      end
    end
  end

  initial begin
    // Reset, with a next_line pulse that must be ignored.
    idle(1);
    next_line = 1'b1;
    step();
    next_line = 1'b0;
    idle(2);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_lb_sel", lb_sel, 0);
    check_eq("rst_line_idx", line_idx, 0);
    check_eq("rst_ovr_cnt", overrun_cnt, 0);
    rst = 1'b0;
    idle(3);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_lb_sel", lb_sel, 0);

    // Full line, all stages; wrong-stage and start-cycle dones are ignored.
    line(1'b0, 1'b1, 3'b111, 1'b0, 3'b000);
    check_eq("l0_busy", busy, 1);
    done_pulse(3'b001, 3'b000);            // done_l0 during start cycle
    done_pulse(3'b110, 3'b000);            // wrong-stage dones
    idle(2);
    done_pulse(3'b001, 3'b010);            // -> L1
    idle(3);
    done_pulse(3'b010, 3'b001);            // -> SPR
    idle(3);
    done_pulse(3'b100, 3'b000);            // -> DONE
    check_eq("done_busy", busy, 0);
    check_eq("done_lb_sel", lb_sel, 1);
    check_eq("done_line_idx", line_idx, 1);
    idle(2);
    check_eq("done_hold_busy", busy, 0);

    // Sprites only.
    line(1'b0, 1'b0, 3'b100, 1'b0, 3'b000);
    idle(2);
    done_pulse(3'b100, 3'b000);
    check_eq("spr_only_busy", busy, 0);

    // No stages enabled.
    line(1'b0, 1'b1, 3'b000, 1'b0, 3'b000);
    check_eq("none_busy", busy, 0);
    idle(2);
    check_eq("none_busy_hold", busy, 0);

    // Overrun while in L1.
    line(1'b0, 1'b0, 3'b111, 1'b0, 3'b000);
    idle(1);
    done_pulse(3'b001, 3'b010);
    idle(2);
    line(1'b0, 1'b1, 3'b111, 1'b1, 3'b000);
    check_eq("ovr_l1_busy", busy, 1);

    // Run to SPR, then done_spr coincides with next_line: no overrun.
    idle(1);
    done_pulse(3'b001, 3'b010);
    idle(1);
    done_pulse(3'b010, 3'b001);
    idle(2);
    line(1'b0, 1'b0, 3'b111, 1'b0, 3'b100);

    // next_line in the start cycle is an overrun.
    line(1'b0, 1'b1, 3'b011, 1'b1, 3'b000);

    // Overrun in a stage that is not the last one, with a same-cycle done.
    idle(1);
    line(1'b0, 1'b0, 3'b011, 1'b1, 3'b001);

    // 300 consecutive overruns, then next_frame lines.
    for (int i = 0; i < 300; i++) line(1'b0, i[0], 3'b111, 1'b1, 3'b000);
`ifdef LINE_SCHED_OVERRUN_CNT_EN
    check_eq("sat_cnt", overrun_cnt, 255);
`else
    check_eq("sat_cnt", overrun_cnt, 0);
`endif
    line(1'b1, 1'b1, 3'b111, 1'b1, 3'b000);
    check_eq("frame_idx", line_idx, 0);
    check_eq("frame_field", render_field, 1);
    idle(1);
    done_pulse(3'b001, 3'b010);
    idle(1);
    done_pulse(3'b010, 3'b001);
    idle(1);
    done_pulse(3'b100, 3'b000);
    line(1'b1, 1'b0, 3'b111, 1'b0, 3'b000);
    check_eq("frame2_cnt", overrun_cnt, 0);
    check_eq("frame2_field", render_field, 0);
    check_eq("frame2_idx", line_idx, 0);

    // Reset mid-line: no abort, everything cleared.
    idle(2);
    rst = 1'b1;
    step();
    check_eq("midrst_abort", abort, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_lb_sel", lb_sel, 0);
    rst = 1'b0;
    lb_m = 1'b0; idx_m = '0; fld_m = 1'b0; cnt_m = '0;
    idle(2);
    line(1'b0, 1'b1, 3'b010, 1'b0, 3'b000);
    check_eq("postrst_idx", line_idx, 1);
    idle(2);

    check_eq("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_render_sched.md
LINE_RENDER_SCHED -- requirements
Module: line_render_sched

Interface
REQ-001 Parameters SHALL be:
- LINE_W, 9, width of line_idx
- OVR_W, 8, width of overrun_cnt
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- next_line  in  1  one-cycle pulse from the video timing generator, start of the next render line
- next_frame  in  1  one-cycle pulse; always coincides with a next_line pulse
- current_field  in  1  interlace field of the frame being started
- layer0_en, layer1_en, sprites_en  in  1 each  render-stage enables
- start_l0, start_l1, start_spr  out  1 each  one-cycle stage start pulses
- done_l0, done_l1, done_spr  in  1 each  one-cycle stage completion pulses
- abort  out  1  one-cycle pulse; stops the active renderer
- lb_sel  out  1  line-buffer bank being rendered
- line_idx  out  LINE_W  line number being rendered
- render_field  out  1  field latched at line start
- busy  out  1  high while any stage is active
- overrun  out  1  one-cycle pulse on an unfinished line
- overrun_cnt  out  OVR_W  count of overrun lines

Function
REQ-003 The FSM SHALL have states IDLE, L0, L1, SPR, DONE, and SHALL leave IDLE only on next_line.
REQ-004 On next_line in any state, the block SHALL, in the next cycle:
- toggle lb_sel
- latch render_field from current_field
- sample the three enables for the whole line
- enter the first enabled stage in the order L0, L1, SPR, or DONE if none is enabled
REQ-005 On next_line, line_idx SHALL be set to 0 if next_frame is high, otherwise incremented modulo 2^LINE_W.
REQ-006 The start pulse of a stage SHALL be high exactly in the first cycle in that stage and low in every other cycle.
REQ-007 A done pulse SHALL be accepted only in its own stage and only when that stage's start pulse is low; done pulses in any other state or cycle SHALL be ignored.
REQ-008 On an accepted done, the FSM SHALL move to the next enabled stage in order, or to DONE after the last enabled stage, in the next cycle.
REQ-009 With no next_line, DONE SHALL hold.
REQ-010 busy SHALL equal (state is L0, L1 or SPR).
REQ-011 next_line arriving while busy SHALL cause, in the next cycle:
- a one-cycle abort pulse
- a one-cycle overrun pulse
- the line restart per REQ-004
REQ-012 If an accepted done of the last enabled stage coincides with next_line, the line SHALL count as complete: no abort, no overrun.
REQ-013 If next_line coincides with a start pulse cycle, the line SHALL be treated as an overrun per REQ-011.
REQ-014 All outputs SHALL be registered.

Reset
REQ-015 While rst is high, the block SHALL hold:
- state = IDLE
- lb_sel = 0, line_idx = 0, render_field = 0
- all pulse outputs = 0
- busy = 0, overrun_cnt = 0
REQ-016 next_line coincident with rst SHALL be ignored.
REQ-017 Reset mid-line SHALL NOT generate abort.

Configuration
REQ-018 With macro LINE_SCHED_OVERRUN_CNT_EN defined, overrun_cnt SHALL:
- increment on each overrun pulse
- saturate at 2^OVR_W-1
- clear to 0 on next_frame; a same-cycle overrun then yields a count of 1
REQ-019 Without LINE_SCHED_OVERRUN_CNT_EN, overrun_cnt SHALL be constant 0; the overrun pulse is unaffected.

Verification
REQ-020 All enables 1; next_line at cycle 10; done_l0 at 15, done_l1 at 20, done_spr at 25 -> required response:
- start_l0 at cycle 11, start_l1 at 16, start_spr at 21
- DONE state at cycle 26, busy low from 26
- lb_sel=1, line_idx=1
REQ-021 Only sprites_en=1; next_line -> start_spr one cycle later; start_l0 and start_l1 never pulse.
REQ-022 All enables 0 -> DONE one cycle after next_line; busy stays 0; no start pulse.
REQ-023 Stage L1 active; second next_line arrives -> required response:
- abort and overrun pulse one cycle later
- start_l0 pulses that same cycle
- overrun_cnt=1 (macro defined) or 0 (macro undefined)
REQ-024 done_spr coincides with next_line -> no overrun; next line starts normally.
REQ-025 300 consecutive overruns, then next_frame -> required response:
- overrun_cnt saturates at 255 before next_frame
- overrun_cnt=0 after next_frame if that line completes, 1 if next_frame coincides with an overrun
- line_idx=0
- render_field follows current_field
